// File: rtl/regfile_tagged_if.sv
// Bus bundle for regfile_tagged: rs/rt read ports, write port, monitor port,
// clear/dump control and the dump stream handshake.
interface regfile_tagged_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int TW    = 4
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [TW-1:0] rs_tag;
  logic [TW-1:0] rt_tag;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [TW-1:0] wr_tag;
  logic [AW-1:0] mon_addr;
  logic [DW-1:0] mon_data;
  logic [TW-1:0] mon_tag;
  logic          clr_req;
  logic          clr_busy;
  logic          dump_req;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic [TW-1:0] dump_tag;
  logic          dump_done;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data, wr_tag, mon_addr,
           clr_req, dump_req, dump_ready,
    input  rs_data, rs_tag, rt_data, rt_tag, mon_data, mon_tag, clr_busy,
           dump_valid, dump_addr, dump_data, dump_tag, dump_done
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data, wr_tag, mon_addr,
           clr_req, dump_req, dump_ready,
    output rs_data, rs_tag, rt_data, rt_tag, mon_data, mon_tag, clr_busy,
           dump_valid, dump_addr, dump_data, dump_tag, dump_done
  );
endinterface

// File: rtl/regfile_tagged.sv
// Tagged register file: two forwarding read ports, one write port, a monitor
// port, a sequential clear engine and a snapshot-per-entry dump streamer.
module regfile_tagged #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int TW       = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  regfile_tagged_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DUMP = 2'd2} state_t;

  logic [DW-1:0] mem_q [DEPTH];
  logic [TW-1:0] tag_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          clr_busy_q, clr_busy_d;
  logic          dump_valid_q, dump_valid_d;
  logic          dump_done_q, dump_done_d;
  logic [AW-1:0] dump_addr_q, dump_addr_d;
  logic [DW-1:0] dump_data_q, dump_data_d;
  logic [TW-1:0] dump_tag_q, dump_tag_d;

  logic          wr_ok_s;
  logic          we_s;
  logic [AW-1:0] we_addr_s;
  logic [DW-1:0] we_data_s;
  logic [TW-1:0] we_tag_s;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(DEPTH));
  endfunction

  function automatic logic hard_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 1'b0) && (a == {AW{1'b0}});
  endfunction

  function automatic logic [TW+DW-1:0] rd_entry(input logic [AW-1:0] a);
    logic [TW+DW-1:0] e;
    if (in_range(a) && !hard_zero(a)) begin
      e = {tag_q[a], mem_q[a]};
    end else begin
      e = {(TW+DW){1'b0}};
    end
    return e;
  endfunction

  // An external write lands only outside CLEAR and only on a real, writable entry.
  always_comb begin
    wr_ok_s = bus.wr_en && (state_q != CLEAR) && in_range(bus.wr_addr) && !hard_zero(bus.wr_addr);
  end

  // Combinational read ports; the monitor port never sees forwarded data.
  always_comb begin
    {bus.mon_tag, bus.mon_data} = rd_entry(bus.mon_addr);
    if (BYPASS && wr_ok_s && (bus.rs_addr == bus.wr_addr)) begin
      {bus.rs_tag, bus.rs_data} = {bus.wr_tag, bus.wr_data};
    end else begin
      {bus.rs_tag, bus.rs_data} = rd_entry(bus.rs_addr);
    end
    if (BYPASS && wr_ok_s && (bus.rt_addr == bus.wr_addr)) begin
      {bus.rt_tag, bus.rt_data} = {bus.wr_tag, bus.wr_data};
    end else begin
      {bus.rt_tag, bus.rt_data} = rd_entry(bus.rt_addr);
    end
  end

  // Next-state for the clear/dump controller and the storage write mux.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    clr_busy_d   = 1'b0;
    dump_valid_d = dump_valid_q;
    dump_done_d  = 1'b0;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    dump_tag_d   = dump_tag_q;
    we_s         = wr_ok_s;
    we_addr_s    = bus.wr_addr;
    we_data_s    = bus.wr_data;
    we_tag_s     = bus.wr_tag;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d    = CLEAR;
          idx_d      = {AW{1'b0}};
          clr_busy_d = 1'b1;
        end else if (bus.dump_req) begin
          state_d      = DUMP;
          dump_valid_d = 1'b1;
          dump_addr_d  = {AW{1'b0}};
          {dump_tag_d, dump_data_d} = rd_entry({AW{1'b0}});
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        // The clear owns the write port; external writes are simply lost.
        we_s      = 1'b1;
        we_addr_s = idx_q;
        we_data_s = {DW{1'b0}};
        we_tag_s  = {TW{1'b0}};
        if (idx_q == LAST) begin
          state_d = IDLE;
        end else begin
          idx_d      = idx_q + AW'(1);
          clr_busy_d = 1'b1;
        end
      end
      DUMP: begin
        if (dump_valid_q && bus.dump_ready) begin
          if (dump_addr_q == LAST) begin
            dump_valid_d = 1'b0;
            dump_done_d  = 1'b1;
            state_d      = IDLE;
          end else begin
            // Snapshot the next entry from storage at the acceptance edge.
            dump_addr_d = dump_addr_q + AW'(1);
            {dump_tag_d, dump_data_d} = rd_entry(dump_addr_q + AW'(1));
          end
        end else begin
          dump_valid_d = dump_valid_q;
        end
      end
      default: begin
        state_d      = IDLE;
        dump_valid_d = 1'b0;
      end
    endcase
  end

  // Controller and dump output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= {AW{1'b0}};
      clr_busy_q   <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      dump_addr_q  <= {AW{1'b0}};
      dump_data_q  <= {DW{1'b0}};
      dump_tag_q   <= {TW{1'b0}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      clr_busy_q   <= clr_busy_d;
      dump_valid_q <= dump_valid_d;
      dump_done_q  <= dump_done_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      dump_tag_q   <= dump_tag_d;
    end
  end

  // Entry storage with single write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
        tag_q[i] <= {TW{1'b0}};
      end
    end else if (we_s) begin
      mem_q[we_addr_s] <= we_data_s;
      tag_q[we_addr_s] <= we_tag_s;
    end
  end

  assign bus.clr_busy   = clr_busy_q;
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_done  = dump_done_q;
  assign bus.dump_addr  = dump_addr_q;
  assign bus.dump_data  = dump_data_q;
  assign bus.dump_tag   = dump_tag_q;
endmodule

// File: tb/tb_regfile_tagged.sv
// Self-checking bench for regfile_tagged: shadow model plus expected-value queue.
module tb_regfile_tagged;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int TW = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [31:0] model_d [DEPTH];
  logic [3:0]  model_t [DEPTH];
  exp_t q [$];

  regfile_tagged_if #(.DW(DW), .DEPTH(DEPTH), .TW(TW)) bus ();

  regfile_tagged #(.DW(DW), .DEPTH(DEPTH), .TW(TW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] t);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_tag = t;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    if (a != 5'd0) begin model_d[a] = d; model_t[a] = t; end
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) begin model_d[i] = 32'd0; model_t[i] = 4'd0; end
  endtask

  function automatic exp_t mk(input int i, input logic [31:0] d, input logic [3:0] t);
    exp_t e;
    e.a = 5'(i); e.d = d; e.t = t;
    return e;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; bus.rs_addr = 5'd5; bus.rt_addr = 5'd9; bus.mon_addr = 5'd31;
    #1;
    checks++; if (bus.rs_data !== 32'd0) begin failures++; $display("FAIL reset_rs_data got %h want 0", bus.rs_data); end
    checks++; if (bus.rt_tag !== 4'd0) begin failures++; $display("FAIL reset_rt_tag got %h want 0", bus.rt_tag); end
    checks++; if (bus.mon_data !== 32'd0) begin failures++; $display("FAIL reset_mon_data got %h want 0", bus.mon_data); end
    checks++; if ({bus.clr_busy, bus.dump_valid, bus.dump_done} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got %b want 000", {bus.clr_busy, bus.dump_valid, bus.dump_done}); end
    checks++; if ({bus.dump_addr, bus.dump_data, bus.dump_tag} !== 41'd0) begin
      failures++; $display("FAIL reset_dump_payload got %h want 0", {bus.dump_addr, bus.dump_data, bus.dump_tag}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts in the same half-cycle reset drops, so the write hits the first rising edge.
  task automatic test_rw_bypass();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF; bus.wr_tag = 4'd3;
    bus.rs_addr = 5'd5; bus.rt_addr = 5'd5; bus.mon_addr = 5'd5;
    #1;
    checks++; if ({bus.rs_tag, bus.rs_data} !== {4'd3, 32'hDEADBEEF}) begin
      failures++; $display("FAIL bypass_rs got %h want %h", {bus.rs_tag, bus.rs_data}, {4'd3, 32'hDEADBEEF}); end
    checks++; if (bus.rt_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rt got %h want deadbeef", bus.rt_data); end
    checks++; if (bus.mon_data !== 32'd0) begin failures++; $display("FAIL mon_no_bypass got %h want 0", bus.mon_data); end
    @(posedge clk); #1;
    bus.wr_en = 1'b0; model_d[5] = 32'hDEADBEEF; model_t[5] = 4'd3;
    #1;
    checks++; if ({bus.rs_tag, bus.rs_data} !== {4'd3, 32'hDEADBEEF}) begin
      failures++; $display("FAIL stored_rs got %h want %h", {bus.rs_tag, bus.rs_data}, {4'd3, 32'hDEADBEEF}); end
    checks++; if ({bus.mon_tag, bus.mon_data} !== {4'd3, 32'hDEADBEEF}) begin
      failures++; $display("FAIL stored_mon got %h want %h", {bus.mon_tag, bus.mon_data}, {4'd3, 32'hDEADBEEF}); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234; bus.wr_tag = 4'd5;
    bus.rs_addr = 5'd0; bus.rt_addr = 5'd0; bus.mon_addr = 5'd0;
    #1;
    checks++; if (bus.rs_data !== 32'd0) begin failures++; $display("FAIL zero_no_bypass got %h want 0", bus.rs_data); end
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    #1;
    checks++; if (bus.rs_data !== 32'd0) begin failures++; $display("FAIL zero_rs_data got %h want 0", bus.rs_data); end
    checks++; if (bus.rt_tag !== 4'd0) begin failures++; $display("FAIL zero_rt_tag got %h want 0", bus.rt_tag); end
    checks++; if (bus.mon_data !== 32'd0) begin failures++; $display("FAIL zero_mon_data got %h want 0", bus.mon_data); end
  endtask

  task automatic test_fill_read();
    exp_t e;
    for (int i = 0; i < DEPTH; i++) wr(5'(i), $urandom, 4'($urandom_range(15)));
    for (int i = 0; i < DEPTH; i++) begin
      q.push_back(mk(i, model_d[i], model_t[i]));
      q.push_back(mk(DEPTH - 1 - i, model_d[DEPTH-1-i], model_t[DEPTH-1-i]));
    end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      bus.rs_addr = 5'(i); bus.rt_addr = 5'(DEPTH - 1 - i);
      #1;
      e = q.pop_front();
      checks++; if ({bus.rs_tag, bus.rs_data} !== {e.t, e.d}) begin
        failures++; $display("FAIL fill_rs[%0d] got %h want %h", e.a, {bus.rs_tag, bus.rs_data}, {e.t, e.d}); end
      e = q.pop_front();
      checks++; if ({bus.rt_tag, bus.rt_data} !== {e.t, e.d}) begin
        failures++; $display("FAIL fill_rt[%0d] got %h want %h", e.a, {bus.rt_tag, bus.rt_data}, {e.t, e.d}); end
    end
  endtask

  task automatic test_clear();
    int n;
    exp_t e;
    @(negedge clk);
    bus.clr_req = 1'b1; bus.dump_req = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h77; bus.wr_tag = 4'd7;
    @(posedge clk); #1;
    bus.clr_req = 1'b0; bus.dump_req = 1'b0; bus.wr_en = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.clr_busy) break;
      n++;
      bus.wr_en = (c == 20);
      bus.wr_addr = 5'd7; bus.wr_data = 32'h5555; bus.wr_tag = 4'd5;
      bus.dump_req = (c == 10);
    end
    bus.wr_en = 1'b0; bus.dump_req = 1'b0;
    checks++; if (n !== 32) begin failures++; $display("FAIL clr_busy_cycles got %0d want 32", n); end
    checks++; if (bus.dump_valid !== 1'b0) begin failures++; $display("FAIL clr_dump_ignored got %b want 0", bus.dump_valid); end
    model_zero();
    for (int i = 0; i < DEPTH; i++) q.push_back(mk(i, model_d[i], model_t[i]));
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      bus.mon_addr = 5'(i);
      #1;
      e = q.pop_front();
      checks++; if ({bus.mon_tag, bus.mon_data} !== {e.t, e.d}) begin
        failures++; $display("FAIL clr_entry[%0d] got %h want %h", e.a, {bus.mon_tag, bus.mon_data}, {e.t, e.d}); end
    end
  endtask

  task automatic test_dump_stall();
    exp_t e, held;
    bit held_v, tog;
    int xfers, dones, done_at, extra;
    for (int i = 0; i < DEPTH; i++) wr(5'(i), 32'(i * 3), 4'(i));
    q.delete();
    @(negedge clk);
    bus.dump_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) q.push_back(mk(i, model_d[i], model_t[i]));
    @(posedge clk); #1;
    bus.dump_req = 1'b0;
    held = '0; held_v = 1'b0; tog = 1'b0; xfers = 0; dones = 0; done_at = -1; extra = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.dump_done) begin dones++; done_at = xfers; end
      if (bus.dump_valid) begin
        if (held_v) begin
          checks++; if ({bus.dump_addr, bus.dump_data, bus.dump_tag} !== held) begin
            failures++; $display("FAIL dump_hold got %h want %h", {bus.dump_addr, bus.dump_data, bus.dump_tag}, held); end
        end
        bus.dump_ready = tog; tog = ~tog;
        if (bus.dump_ready) begin
          e = (q.size() > 0) ? q.pop_front() : '0;
          checks++; if ({bus.dump_addr, bus.dump_data, bus.dump_tag} !== e) begin
            failures++; $display("FAIL dump_stream got %h want %h", {bus.dump_addr, bus.dump_data, bus.dump_tag}, e); end
          xfers++; held_v = 1'b0;
        end else begin
          held_v = 1'b1; held = {bus.dump_addr, bus.dump_data, bus.dump_tag};
        end
      end else begin
        bus.dump_ready = 1'b0; held_v = 1'b0;
      end
      if (xfers >= 32) begin extra++; if (extra > 3) break; end
    end
    bus.dump_ready = 1'b0;
    checks++; if (xfers !== 32) begin failures++; $display("FAIL dump_xfers got %0d want 32", xfers); end
    checks++; if (dones !== 1 || done_at !== 32) begin
      failures++; $display("FAIL dump_done got pulses=%0d at=%0d want pulses=1 at=32", dones, done_at); end
    checks++; if (bus.dump_valid !== 1'b0) begin failures++; $display("FAIL dump_valid_end got %b want 0", bus.dump_valid); end
  endtask

  task automatic test_dump_coherent();
    exp_t e;
    int xfers, dones, extra;
    bit w2, w20, rd;
    q.delete();
    @(negedge clk);
    bus.dump_req = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      q.push_back(mk(i, (i == 20) ? 32'hAAAA : model_d[i], (i == 20) ? 4'hA : model_t[i]));
    @(posedge clk); #1;
    bus.dump_req = 1'b0; bus.dump_ready = 1'b1;
    xfers = 0; dones = 0; extra = 0; w2 = 1'b0; w20 = 1'b0; rd = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      if (bus.dump_done) dones++;
      if (bus.dump_valid) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        checks++; if ({bus.dump_addr, bus.dump_data, bus.dump_tag} !== e) begin
          failures++; $display("FAIL dump_coherent got %h want %h", {bus.dump_addr, bus.dump_data, bus.dump_tag}, e); end
        xfers++;
      end
      if (xfers == 4 && !w2) begin
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'hBBBB; bus.wr_tag = 4'hB; w2 = 1'b1;
      end else if (xfers == 5 && !w20) begin
        bus.wr_en = 1'b1; bus.wr_addr = 5'd20; bus.wr_data = 32'hAAAA; bus.wr_tag = 4'hA; w20 = 1'b1;
      end else if (xfers == 10 && !rd) begin
        bus.rs_addr = 5'd2; bus.mon_addr = 5'd20; rd = 1'b1;
        #1;
        checks++; if ({bus.rs_tag, bus.rs_data} !== {4'hB, 32'hBBBB}) begin
          failures++; $display("FAIL dump_live_rs got %h want %h", {bus.rs_tag, bus.rs_data}, {4'hB, 32'hBBBB}); end
        checks++; if ({bus.mon_tag, bus.mon_data} !== {4'hA, 32'hAAAA}) begin
          failures++; $display("FAIL dump_live_mon got %h want %h", {bus.mon_tag, bus.mon_data}, {4'hA, 32'hAAAA}); end
      end
      if (xfers >= 32) begin extra++; if (extra > 3) break; end
    end
    bus.wr_en = 1'b0; bus.dump_ready = 1'b0;
    model_d[2] = 32'hBBBB; model_t[2] = 4'hB; model_d[20] = 32'hAAAA; model_t[20] = 4'hA;
    checks++; if (xfers !== 32 || dones !== 1) begin
      failures++; $display("FAIL dump_coh_end got xfers=%0d done=%0d want 32/1", xfers, dones); end
  endtask

  task automatic test_reset_mid_dump();
    exp_t e;
    int at, dones, xfers, extra;
    q.delete();
    @(negedge clk);
    bus.dump_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) q.push_back(mk(i, model_d[i], model_t[i]));
    @(posedge clk); #1;
    bus.dump_req = 1'b0; bus.dump_ready = 1'b1;
    at = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.dump_valid) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        checks++; if ({bus.dump_addr, bus.dump_data, bus.dump_tag} !== e) begin
          failures++; $display("FAIL abort_stream got %h want %h", {bus.dump_addr, bus.dump_data, bus.dump_tag}, e); end
        if (bus.dump_addr == 5'd10) begin at = c; break; end
      end
    end
    checks++; if (at < 0) begin failures++; $display("FAIL abort_reach10 got none want entry 10"); end
    reset = 1'b1; bus.dump_ready = 1'b0;
    bus.rs_addr = 5'd20; bus.rt_addr = 5'd21; bus.mon_addr = 5'd22;
    #1;
    checks++; if ({bus.dump_valid, bus.dump_done, bus.clr_busy} !== 3'b000) begin
      failures++; $display("FAIL abort_flags got %b want 000", {bus.dump_valid, bus.dump_done, bus.clr_busy}); end
    checks++; if ({bus.dump_addr, bus.dump_data, bus.dump_tag} !== 41'd0) begin
      failures++; $display("FAIL abort_payload got %h want 0", {bus.dump_addr, bus.dump_data, bus.dump_tag}); end
    checks++; if ({bus.rs_data, bus.rt_data, bus.mon_data, bus.rs_tag, bus.rt_tag, bus.mon_tag} !== 108'd0) begin
      failures++; $display("FAIL abort_reads got %h/%h/%h want 0", bus.rs_data, bus.rt_data, bus.mon_data); end
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.dump_done) dones++;
      if (c == 1) reset = 1'b0;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done got %0d want 0", dones); end
    model_zero();
    q.delete();
    bus.dump_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) q.push_back(mk(i, model_d[i], model_t[i]));
    @(posedge clk); #1;
    bus.dump_req = 1'b0; bus.dump_ready = 1'b1;
    xfers = 0; extra = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.dump_done) dones++;
      if (bus.dump_valid) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        checks++; if ({bus.dump_addr, bus.dump_data, bus.dump_tag} !== e) begin
          failures++; $display("FAIL redump_stream got %h want %h", {bus.dump_addr, bus.dump_data, bus.dump_tag}, e); end
        xfers++;
      end
      if (xfers >= 32) begin extra++; if (extra > 3) break; end
    end
    bus.dump_ready = 1'b0;
    checks++; if (xfers !== 32 || dones !== 1) begin
      failures++; $display("FAIL redump_end got xfers=%0d done=%0d want 32/1", xfers, dones); end
  endtask

  initial begin
    reset = 1'b1;
    bus.rs_addr = 5'd0; bus.rt_addr = 5'd0; bus.mon_addr = 5'd0;
    bus.wr_en = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0; bus.wr_tag = 4'd0;
    bus.clr_req = 1'b0; bus.dump_req = 1'b0; bus.dump_ready = 1'b0;
    model_zero();
    test_reset();
    test_rw_bypass();
    test_zero_reg();
    test_fill_read();
    test_clear();
    test_dump_stall();
    test_dump_coherent();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
